// File: rtl/uart_tx_sched_if.sv
// Requester/transmitter bundle for the UART byte scheduler: four byte
// requesters on one side, the UART start/data strobe and status on the other.
interface uart_tx_sched_if;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        uart_start;
    logic [7:0]  uart_data;
    logic [1:0]  grant_id;
    logic        grant_active;
    logic        frame_done;
    logic        timeout_err;

    modport master (
        output req_valid, req_data, req_last,
        input  req_ready, uart_start, uart_data, grant_id, grant_active,
               frame_done, timeout_err
    );

    modport slave (
        input  req_valid, req_data, req_last,
        output req_ready, uart_start, uart_data, grant_id, grant_active,
               frame_done, timeout_err
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler feeding one byte per UART frame from four packet requesters.
// Optional mid-packet idle timeout is enabled by defining UART_SCHED_TIMEOUT_EN.
module uart_tx_sched #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 115200,
    parameter int TIMEOUT_CLKS = 65535
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_sched_if.slave bus
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int FRAME_CLKS   = 10 * CLKS_PER_BIT;
    localparam int FRAME_W      = ($clog2(FRAME_CLKS) > 16) ? $clog2(FRAME_CLKS) : 16;
    localparam logic [FRAME_W-1:0] FRAME_LOAD = FRAME_W'(FRAME_CLKS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         r_grant_id;
    logic [1:0]         r_rr_ptr;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic               r_last;
    logic               r_uart_start;
    logic [7:0]         r_uart_data;

    logic [1:0] w_pick;
    logic       w_any;
    logic [3:0] w_ready;
    logic       w_hs;
    logic [7:0] w_sel_data;
    logic       w_sel_last;
    logic       w_frame_end;
    logic       w_timeout;

    // Smallest offset from rr_ptr wins, so scan offsets from high to low.
    always_comb begin
        w_pick = r_rr_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (bus.req_valid[r_rr_ptr + 2'(k)]) begin
                w_pick = r_rr_ptr + 2'(k);
            end
        end
    end

    assign w_any = |bus.req_valid;

    for (genvar gi = 0; gi < 4; gi++) begin : g_ready
        assign w_ready[gi] = (r_state == ST_GRANT) && (r_grant_id == 2'(gi));
    end

    assign w_hs        = |(bus.req_valid & w_ready);
    assign w_sel_data  = bus.req_data[{r_grant_id, 3'b000} +: 8];
    assign w_sel_last  = bus.req_last[r_grant_id];
    assign w_frame_end = (r_state == ST_WAIT) && (r_frame_cnt == '0);

`ifdef UART_SCHED_TIMEOUT_EN
    localparam int IDLE_W = ($clog2(TIMEOUT_CLKS) > 0) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CLKS - 1);

    logic [IDLE_W-1:0] r_idle_cnt;

    // Held at zero outside GRANT, so every entry into GRANT starts a fresh count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= '0;
        end else if ((r_state != ST_GRANT) || w_hs) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == ST_GRANT) && !w_hs && (r_idle_cnt == IDLE_LIMIT);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_grant_id   <= 2'd0;
            r_rr_ptr     <= 2'd0;
            r_frame_cnt  <= '0;
            r_last       <= 1'b0;
            r_uart_start <= 1'b0;
            r_uart_data  <= 8'h00;
        end else begin
            r_uart_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant_id <= w_pick;
                        r_state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (w_hs) begin
                        r_uart_data  <= w_sel_data;
                        r_last       <= w_sel_last;
                        r_uart_start <= 1'b1;
                        r_frame_cnt  <= FRAME_LOAD;
                        r_state      <= ST_WAIT;
                    end else if (w_timeout) begin
                        r_rr_ptr <= r_grant_id + 2'd1;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    // The extra GRANT cycle after the frame guarantees a full stop bit.
                    if (r_frame_cnt == '0) begin
                        if (r_last) begin
                            r_rr_ptr <= r_grant_id + 2'd1;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_state <= ST_GRANT;
                        end
                    end else begin
                        r_frame_cnt <= r_frame_cnt - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready    = w_ready;
    assign bus.uart_start   = r_uart_start;
    assign bus.uart_data    = r_uart_data;
    assign bus.grant_id     = r_grant_id;
    assign bus.grant_active = (r_state == ST_GRANT) || (r_state == ST_WAIT);
    assign bus.frame_done   = w_frame_end;
    assign bus.timeout_err  = w_timeout;
endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameters SHALL be: CLK_FREQ, default 50000000, system clock in Hz.
REQ-002 BAUD, default 115200, line rate.
REQ-003 TIMEOUT_CLKS, default 65535, mid-packet idle limit in cycles (used only with UART_SCHED_TIMEOUT_EN).
REQ-004 Derived constants SHALL be CLKS_PER_BIT = CLK_FREQ/BAUD (integer division) and FRAME_CLKS = 10*CLKS_PER_BIT; the frame counter SHALL be at least 16 bits wide.
REQ-005 clk  in  1  system clock, rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 req_valid  in  4  per-requester byte valid.
REQ-008 req_data  in  32  requester i byte on [8i+7:8i].
REQ-009 req_last  in  4  marks the final byte of a packet, sampled with req_data.
REQ-010 req_ready  out  4  one-hot acceptance; a byte transfers when req_valid[i] && req_ready[i].
REQ-011 uart_start  out  1  one-cycle start pulse to the UART transmitter.
REQ-012 uart_data  out  8  byte to the transmitter; stable from uart_start until the next uart_start.
REQ-013 grant_id  out  2  current or last owner.
REQ-014 grant_active  out  1  a requester owns the link.
REQ-015 frame_done  out  1  one-cycle pulse when a frame time expires.
REQ-016 timeout_err  out  1  one-cycle pulse on mid-packet timeout; tied 0 without the macro.

Function
REQ-017 The FSM SHALL have states IDLE, GRANT and WAIT; grant_active SHALL be 1 exactly in GRANT and WAIT.
REQ-018 IDLE: when any req_valid is 1, the FSM SHALL register grant_id as the first valid requester at or after rr_ptr (modulo 4) and SHALL enter GRANT on the next edge.
REQ-019 GRANT: req_ready[grant_id] SHALL be 1 combinationally; all other req_ready bits SHALL be 0 in every state.
REQ-020 Handshake in GRANT at cycle N: the block SHALL capture the byte and the last flag, drive uart_data and uart_start=1 in cycle N+1, and enter WAIT with the frame counter at FRAME_CLKS-1.
REQ-021 WAIT: the counter SHALL decrement by 1 per cycle; at 0, frame_done SHALL pulse in that cycle.
REQ-022 At counter 0 with captured last=0, the FSM SHALL return to GRANT with the same owner.
REQ-023 At counter 0 with captured last=1, the FSM SHALL go to IDLE, set rr_ptr=grant_id+1 (wrapping 3->0) and hold grant_id unchanged.
REQ-024 Back-to-back bytes from the same owner SHALL yield uart_start pulses exactly FRAME_CLKS+1 cycles apart, guaranteeing a full stop bit.
REQ-025 A packet SHALL never be interleaved; another requester's valid SHALL be ignored until the owner's last byte frame completes.
REQ-026 In GRANT with req_valid[grant_id]=0, the FSM SHALL hold indefinitely (macro absent).
REQ-027 req_last and req_data of non-granted requesters SHALL be ignored.
REQ-028 A single-byte packet (last=1 on the first byte) SHALL release the grant after one frame.

Reset
REQ-029 On rst_n=0, state SHALL be IDLE; rr_ptr, grant_id, grant_active, req_ready, uart_start, frame_done and timeout_err SHALL be 0; uart_data SHALL be 8'h00; counters SHALL be 0.
REQ-030 Reset mid-frame SHALL abort immediately with no uart_start after release; the UART transmitter shares rst_n.
REQ-031 The first arbitration after reset SHALL favour requester 0.

Configuration
REQ-032 With UART_SCHED_TIMEOUT_EN defined, an idle counter SHALL clear on entering GRANT and SHALL increment each GRANT cycle without a handshake.
REQ-033 When the idle counter reaches TIMEOUT_CLKS-1, the block SHALL pulse timeout_err, go to IDLE and set rr_ptr=grant_id+1.
REQ-034 Without UART_SCHED_TIMEOUT_EN, the counter SHALL not be built and timeout_err SHALL be constant 0.

Verification
Bench parameters: CLK_FREQ=400, BAUD=100 (CLKS_PER_BIT=4, FRAME_CLKS=40), TIMEOUT_CLKS=16.
REQ-035 Req0 sends 3 bytes 0x11,0x22,0x33 (last on 0x33) -> 3 uart_start pulses 41 cycles apart with matching uart_data; grant released 40 cycles after the third pulse; one frame_done per byte.
REQ-036 Req1 and req2 both valid from IDLE after reset -> req1 is granted first; req2 is granted only after req1's last frame; then req3 requesting -> req3 wins over req1 (rr_ptr=3).
REQ-037 Req0 holds valid through a 2-byte packet while req1 is valid throughout -> req1's req_ready stays 0 until req0 is released; no interleaved bytes.
REQ-038 Reset pulsed 10 cycles into WAIT -> all outputs return to 0 within the reset; no further uart_start; requester 0 is favoured afterwards.
REQ-039 Macro defined: req2 is granted, sends one non-last byte, then valid=0 -> timeout_err pulses on the 16th GRANT cycle; FSM goes to IDLE; rr_ptr=3. Macro undefined: same stimulus holds GRANT forever with timeout_err=0.
